// File: rtl/wr_burst_ctrl.sv
// Write-side DMA burst engine: splits a decompressed job into 4 KB-safe write
// bursts, gates output beats against granted bursts and counts write responses.
module wr_burst_ctrl #(
    parameter int ADDR_WIDTH      = 64,
    parameter int DATA_WIDTH      = 512,
    parameter int MAX_BURST       = 64,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [ADDR_WIDTH-1:0]   des_addr,
    input  logic [31:0]             decompression_length,
    output logic                    wr_req,
    output logic [ADDR_WIDTH-1:0]   wr_address,
    output logic [7:0]              wr_len,
    input  logic                    wr_req_ack,
    input  logic [DATA_WIDTH-1:0]   s_data,
    input  logic [DATA_WIDTH/8-1:0] s_strb,
    input  logic                    s_valid,
    output logic                    s_ready,
    output logic [DATA_WIDTH-1:0]   m_wdata,
    output logic [DATA_WIDTH/8-1:0] m_wstrb,
    output logic                    m_wvalid,
    output logic                    m_wlast,
    input  logic                    m_wready,
    output logic                    bready,
    input  logic                    bresp,
    output logic                    idle,
    output logic                    done
);

    localparam int CNT_W = 27;
    localparam int OUT_W = $clog2(MAX_OUTSTANDING) + 1;
    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CALC,
        S_REQ,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t              state;
    logic [ADDR_WIDTH-1:0] cur_addr;
    logic [CNT_W-1:0]    remaining;
    logic [CNT_W-1:0]    total_beats;
    logic [CNT_W-1:0]    granted;
    logic [CNT_W-1:0]    sent;
    logic [OUT_W-1:0]    outstanding;
    logic [7:0]          beat_in_burst;

    logic [7:0]          fifo_mem [MAX_OUTSTANDING];
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [OUT_W-1:0]    fifo_count;

    logic [CNT_W-1:0]    total_calc;
    logic [CNT_W-1:0]    room;
    logic [CNT_W-1:0]    burst;
    logic [8:0]          burst_beats;
    logic                start_fire;
    logic                ack_fire;
    logic                resp_fire;
    logic                eligible;
    logic                beat_fire;
    logic                last_beat;
    logic                push;
    logic                pop;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(MAX_OUTSTANDING - 1)) begin
            return '0;
        end
        return p + PTR_W'(1);
    endfunction

    // Burst size is capped by what is left, the burst limit and the distance to the next 4 KB page.
    always_comb begin
        total_calc  = CNT_W'(({1'b0, decompression_length} + 33'd63) >> 6);
        room        = CNT_W'(7'd64 - {1'b0, cur_addr[11:6]});
        burst       = remaining;
        if (burst > CNT_W'(MAX_BURST)) begin
            burst = CNT_W'(MAX_BURST);
        end
        if (burst > room) begin
            burst = room;
        end
        burst_beats = {1'b0, wr_len} + 9'd1;
    end

    assign start_fire = start && idle;
    assign ack_fire   = wr_req && wr_req_ack;
    assign resp_fire  = bresp && (outstanding != '0);
    assign eligible   = granted > sent;
    assign last_beat  = beat_in_burst == fifo_mem[rd_ptr];
    assign beat_fire  = s_valid && m_wready && eligible;
    assign push       = ack_fire && (fifo_count < OUT_W'(MAX_OUTSTANDING));
    assign pop        = beat_fire && last_beat && (fifo_count != '0);

    assign m_wdata  = s_data;
    assign m_wstrb  = s_strb;
    assign m_wvalid = s_valid && eligible;
    assign s_ready  = m_wready && eligible;
    assign m_wlast  = m_wvalid && last_beat;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            wr_req      <= 1'b0;
            wr_address  <= '0;
            wr_len      <= '0;
            idle        <= 1'b1;
            done        <= 1'b0;
            bready      <= 1'b0;
            cur_addr    <= '0;
            remaining   <= '0;
            total_beats <= '0;
            granted     <= '0;
            outstanding <= '0;
        end else begin
            bready <= 1'b1;
            case ({ack_fire, resp_fire})
                2'b10:   outstanding <= outstanding + OUT_W'(1);
                2'b01:   outstanding <= outstanding - OUT_W'(1);
                default: outstanding <= outstanding;
            endcase
            case (state)
                S_IDLE: begin
                    if (start_fire) begin
                        idle        <= 1'b0;
                        done        <= 1'b0;
                        cur_addr    <= des_addr;
                        remaining   <= total_calc;
                        total_beats <= total_calc;
                        granted     <= '0;
                        state       <= S_CALC;
                    end
                end
                S_CALC: begin
                    if (remaining == '0) begin
                        state <= S_DRAIN;
                    end else if (outstanding < OUT_W'(MAX_OUTSTANDING)) begin
                        wr_req     <= 1'b1;
                        wr_address <= cur_addr;
                        wr_len     <= 8'(burst - CNT_W'(1));
                        state      <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (wr_req_ack) begin
                        wr_req    <= 1'b0;
                        cur_addr  <= cur_addr + (ADDR_WIDTH'(burst_beats) << 6);
                        remaining <= remaining - CNT_W'(burst_beats);
                        granted   <= granted + CNT_W'(burst_beats);
                        state     <= S_CALC;
                    end
                end
                S_DRAIN: begin
                    if ((sent == total_beats) && (outstanding == '0)) begin
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    done  <= 1'b1;
                    idle  <= 1'b1;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sent          <= '0;
            beat_in_burst <= '0;
        end else if (start_fire) begin
            sent          <= '0;
            beat_in_burst <= '0;
        end else if (beat_fire) begin
            sent          <= sent + CNT_W'(1);
            beat_in_burst <= last_beat ? 8'd0 : beat_in_burst + 8'd1;
        end
    end

    // Burst-length FIFO holds wr_len of each granted burst so wlast lines up with its grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                fifo_mem[i] <= '0;
            end
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= wr_len;
                wr_ptr           <= ptr_next(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + OUT_W'(1);
                2'b01:   fifo_count <= fifo_count - OUT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

endmodule

// File: tb/tb_wr_burst_ctrl.sv
// Bench for wr_burst_ctrl: table-driven and randomized jobs against a byte-level
// burst-splitting model, plus hand-written outstanding, reset and timing sequences.
module tb_wr_burst_ctrl;

    localparam int MAX_OUT = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [63:0]  des_addr;
    logic [31:0]  decompression_length;
    logic         wr_req;
    logic [63:0]  wr_address;
    logic [7:0]   wr_len;
    logic         wr_req_ack;
    logic [511:0] s_data;
    logic [63:0]  s_strb;
    logic         s_valid;
    logic         s_ready;
    logic [511:0] m_wdata;
    logic [63:0]  m_wstrb;
    logic         m_wvalid;
    logic         m_wlast;
    logic         m_wready;
    logic         bready;
    logic         bresp;
    logic         idle;
    logic         done;

    int checks = 0;
    int failures = 0;

    logic [63:0] m_addr_q[$];
    logic [7:0]  m_len_q[$];
    bit          exp_last_q[$];

    typedef struct {
        logic [63:0] addr;
        logic [31:0] len;
        int          pct;
        int          exp_bursts;
        int          exp_beats;
        logic [63:0] exp_first_addr;
        logic [7:0]  exp_first_len;
    } vec_t;

    vec_t vecs[6];

    wr_burst_ctrl #(
        .ADDR_WIDTH(64),
        .DATA_WIDTH(512),
        .MAX_BURST(64),
        .MAX_OUTSTANDING(MAX_OUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .des_addr(des_addr),
        .decompression_length(decompression_length),
        .wr_req(wr_req),
        .wr_address(wr_address),
        .wr_len(wr_len),
        .wr_req_ack(wr_req_ack),
        .s_data(s_data),
        .s_strb(s_strb),
        .s_valid(s_valid),
        .s_ready(s_ready),
        .m_wdata(m_wdata),
        .m_wstrb(m_wstrb),
        .m_wvalid(m_wvalid),
        .m_wlast(m_wlast),
        .m_wready(m_wready),
        .bready(bready),
        .bresp(bresp),
        .idle(idle),
        .done(done)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
        end
    endtask

    // Reference: walk the job in bytes, cutting at 64 beats or the next 4096-byte page.
    function automatic void build_model(input logic [63:0] addr, input logic [31:0] len);
        longint unsigned beats_left = ({32'd0, len} + 64'd63) / 64;
        logic [63:0] a = addr;
        m_addr_q.delete();
        m_len_q.delete();
        exp_last_q.delete();
        while (beats_left > 0) begin
            longint unsigned to_page = (4096 - (a % 4096)) / 64;
            longint unsigned b = beats_left;
            if (b > 64) b = 64;
            if (b > to_page) b = to_page;
            m_addr_q.push_back(a);
            m_len_q.push_back(8'(b - 1));
            for (longint unsigned k = 0; k < b; k++) begin
                exp_last_q.push_back(k == b - 1);
            end
            a = a + b * 64;
            beats_left = beats_left - b;
        end
    endfunction

    task automatic applyStimulus(input int pct, input int pending);
        wr_req_ack = wr_req && (int'($urandom_range(0, 99)) < pct);
        s_valid    = int'($urandom_range(0, 99)) < pct;
        for (int i = 0; i < 16; i++) begin
            s_data[i*32 +: 32] = $urandom;
        end
        s_strb   = {$urandom, $urandom};
        m_wready = int'($urandom_range(0, 99)) < pct;
        bresp    = (pending > 0) && (int'($urandom_range(0, 99)) < pct);
    endtask

    task automatic quietInputs();
        start      = 1'b0;
        wr_req_ack = 1'b0;
        s_valid    = 1'b0;
        m_wready   = 1'b0;
        bresp      = 1'b0;
    endtask

    task automatic resetDut();
        quietInputs();
        s_data = '0;
        s_strb = '0;
        des_addr = '0;
        decompression_length = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("rst_wr_req", wr_req, 0);
        checkOutput("rst_wr_address", wr_address, 0);
        checkOutput("rst_wr_len", wr_len, 0);
        checkOutput("rst_s_ready", s_ready, 0);
        checkOutput("rst_m_wvalid", m_wvalid, 0);
        checkOutput("rst_bready", bready, 0);
        checkOutput("rst_idle", idle, 1);
        checkOutput("rst_done", done, 0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("bready_after_rst", bready, 1);
    endtask

    task automatic runJob(input logic [63:0] addr, input logic [31:0] len, input int pct,
                          output int n_bursts, output int n_beats,
                          output logic [63:0] first_addr, output logic [7:0] first_len);
        int req_idx = 0;
        int sent_b = 0;
        int grant_b = 0;
        int bench_out = 0;
        int pending = 0;
        int cycles = 0;
        bit acked;
        bit fired;
        bit resp;
        bit was_last;
        first_addr = '0;
        first_len = '0;
        build_model(addr, len);
        quietInputs();
        des_addr = addr;
        decompression_length = len;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (!done && cycles < 20000) begin
            applyStimulus(pct, pending);
            #1;
            checkOutput("m_wvalid_gate", m_wvalid, s_valid && (grant_b > sent_b));
            checkOutput("s_ready_gate", s_ready, m_wready && (grant_b > sent_b));
            acked = wr_req_ack;
            fired = m_wvalid && m_wready;
            resp = bresp;
            was_last = 1'b0;
            if (fired) begin
                checkOutput("wdata_pass", (m_wdata == s_data) && (m_wstrb == s_strb), 1);
                if (sent_b < exp_last_q.size()) begin
                    was_last = exp_last_q[sent_b];
                    checkOutput("m_wlast", m_wlast, was_last);
                end else begin
                    checkOutput("extra_beat", 1, 0);
                end
            end
            if (acked) begin
                if (req_idx < m_addr_q.size()) begin
                    checkOutput("wr_address", wr_address, m_addr_q[req_idx]);
                    checkOutput("wr_len", wr_len, m_len_q[req_idx]);
                    if (req_idx == 0) begin
                        first_addr = wr_address;
                        first_len = wr_len;
                    end
                end else begin
                    checkOutput("extra_req", 1, 0);
                end
            end
            @(negedge clk);
            cycles++;
            if (acked) begin
                if (req_idx < m_len_q.size()) grant_b += int'(m_len_q[req_idx]) + 1;
                req_idx++;
                bench_out++;
                checkOutput("outstanding_limit", bench_out <= MAX_OUT, 1);
            end
            if (fired) begin
                sent_b++;
                if (was_last) pending++;
            end
            if (resp) begin
                pending--;
                bench_out--;
            end
        end
        quietInputs();
        checkOutput("job_done", done, 1);
        checkOutput("job_idle", idle, 1);
        checkOutput("req_count", req_idx, m_addr_q.size());
        checkOutput("beat_count", sent_b, exp_last_q.size());
        n_bursts = req_idx;
        n_beats = sent_b;
    endtask

    initial begin
        int n_bursts;
        int n_beats;
        int n;
        int acks;
        int beats;
        logic [63:0] first_addr;
        logic [7:0] first_len;
        logic [63:0] r_addr;
        logic [31:0] r_len;

        vecs[0] = '{64'h1000, 32'd4096, 100, 1, 64, 64'h1000, 8'd63};
        vecs[1] = '{64'h0FC0, 32'd200, 70, 2, 4, 64'h0FC0, 8'd0};
        vecs[2] = '{64'h0000, 32'd16384, 80, 4, 256, 64'h0000, 8'd63};
        vecs[3] = '{64'h0040, 32'd1, 60, 1, 1, 64'h0040, 8'd0};
        vecs[4] = '{64'h0F80, 32'd65, 70, 1, 2, 64'h0F80, 8'd1};
        vecs[5] = '{64'h07C0, 32'd4160, 50, 2, 65, 64'h07C0, 8'd32};

        resetDut();

        for (int v = 0; v < 6; v++) begin
            runJob(vecs[v].addr, vecs[v].len, vecs[v].pct, n_bursts, n_beats, first_addr, first_len);
            checkOutput("tbl_bursts", n_bursts, vecs[v].exp_bursts);
            checkOutput("tbl_beats", n_beats, vecs[v].exp_beats);
            checkOutput("tbl_first_addr", first_addr, vecs[v].exp_first_addr);
            checkOutput("tbl_first_len", first_len, vecs[v].exp_first_len);
        end

        for (int j = 0; j < 10; j++) begin
            r_addr = {$urandom, $urandom} & ~64'h3F;
            r_len = ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom_range(1, 12000));
            runJob(r_addr, r_len, int'($urandom_range(40, 100)), n_bursts, n_beats, first_addr, first_len);
        end

        // Outstanding limit, data gating before the first grant, then an abort by reset.
        quietInputs();
        s_valid = 1'b1;
        m_wready = 1'b1;
        des_addr = 64'h0;
        decompression_length = 32'd16384;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!wr_req && n < 10) begin
            #1;
            checkOutput("pre_ack_wvalid", m_wvalid, 0);
            checkOutput("pre_ack_s_ready", s_ready, 0);
            @(negedge clk);
            n++;
        end
        checkOutput("first_req_seen", wr_req, 1);
        wr_req_ack = 1'b1;
        #1;
        checkOutput("ack_cycle_wvalid", m_wvalid, 0);
        @(negedge clk);
        wr_req_ack = 1'b0;
        #1;
        checkOutput("post_ack_wvalid", m_wvalid, 1);
        checkOutput("post_ack_s_ready", s_ready, 1);
        acks = 1;
        beats = 0;
        for (int i = 0; i < 200; i++) begin
            wr_req_ack = wr_req;
            #1;
            if (m_wvalid && m_wready) beats++;
            if (wr_req_ack) acks++;
            @(negedge clk);
        end
        wr_req_ack = 1'b0;
        checkOutput("limit_acks", acks, MAX_OUT);
        checkOutput("limit_beats", beats, 128);
        checkOutput("limit_wr_req_low", wr_req, 0);
        bresp = 1'b1;
        @(negedge clk);
        bresp = 1'b0;
        n = 0;
        while (!wr_req && n < 10) begin
            @(negedge clk);
            n++;
        end
        checkOutput("third_req_seen", wr_req, 1);
        checkOutput("third_req_addr", wr_address, 64'h2000);
        checkOutput("third_req_len", wr_len, 63);
        wr_req_ack = 1'b1;
        @(negedge clk);
        wr_req_ack = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("abort_wr_req", wr_req, 0);
        checkOutput("abort_m_wvalid", m_wvalid, 0);
        checkOutput("abort_s_ready", s_ready, 0);
        checkOutput("abort_m_wlast", m_wlast, 0);
        checkOutput("abort_idle", idle, 1);
        checkOutput("abort_done", done, 0);
        checkOutput("abort_bready", bready, 0);
        checkOutput("abort_wr_address", wr_address, 0);
        @(negedge clk);
        quietInputs();
        rst = 1'b0;
        @(negedge clk);

        // Same-cycle ack and bresp with one burst outstanding; start while busy is ignored.
        s_valid = 1'b1;
        m_wready = 1'b1;
        des_addr = 64'h0FC0;
        decompression_length = 32'd128;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!wr_req && n < 10) begin
            @(negedge clk);
            n++;
        end
        checkOutput("b_first_addr", wr_address, 64'h0FC0);
        wr_req_ack = 1'b1;
        @(negedge clk);
        wr_req_ack = 1'b0;
        des_addr = 64'h8000;
        decompression_length = 32'd4096;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!wr_req && n < 10) begin
            @(negedge clk);
            n++;
        end
        checkOutput("busy_start_ignored_addr", wr_address, 64'h1000);
        checkOutput("b_second_len", wr_len, 0);
        wr_req_ack = 1'b1;
        bresp = 1'b1;
        @(negedge clk);
        wr_req_ack = 1'b0;
        bresp = 1'b0;
        repeat (8) @(negedge clk);
        checkOutput("done_waits_last_bresp", done, 0);
        checkOutput("idle_waits_last_bresp", idle, 0);
        bresp = 1'b1;
        @(negedge clk);
        bresp = 1'b0;
        n = 0;
        while (!done && n < 10) begin
            @(negedge clk);
            n++;
        end
        checkOutput("b_done", done, 1);
        checkOutput("b_idle", idle, 1);
        quietInputs();

        // Zero-length job: done rises on the third edge after the start edge.
        des_addr = 64'h4000;
        decompression_length = 32'd0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkOutput("zero_done_e0", done, 0);
        @(negedge clk);
        checkOutput("zero_wr_req_e1", wr_req, 0);
        @(negedge clk);
        checkOutput("zero_done_e2", done, 0);
        checkOutput("zero_wr_req_e2", wr_req, 0);
        @(negedge clk);
        checkOutput("zero_done_e3", done, 1);
        checkOutput("zero_idle_e3", idle, 1);
        repeat (3) @(negedge clk);
        checkOutput("zero_done_holds", done, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wr_burst_ctrl.md
Name: wr_burst_ctrl

Overview:
- Write-side DMA burst engine. Sits directly downstream of the decompressor output stream and upstream of the host-memory write channel.
- Splits a decompressed job of `decompression_length` bytes into AXI-style write bursts and issues the burst requests.
- Gates output beats so they flow only against granted bursts, and generates `wlast` per burst.
- Counts write responses and asserts `done` once every burst has been acknowledged.

Parameters:
ADDR_WIDTH, 64, byte address width
DATA_WIDTH, 512, beat width in bits (beat = DATA_WIDTH/8 = 64 bytes)
MAX_BURST, 64, max beats per burst (≤256)
MAX_OUTSTANDING, 8, max bursts granted but not yet responded; power of 2

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
start  in  1  one-cycle job start pulse
des_addr  in  ADDR_WIDTH  job destination byte address, 64B aligned
decompression_length  in  32  job size in bytes
wr_req  out  1  burst request valid
wr_address  out  ADDR_WIDTH  burst start address
wr_len  out  8  burst beats minus 1
wr_req_ack  in  1  request accepted
s_data  in  DATA_WIDTH  upstream beat data
s_strb  in  DATA_WIDTH/8  upstream byte valid
s_valid  in  1  upstream beat valid
s_ready  out  1  upstream beat accepted
m_wdata  out  DATA_WIDTH  write data (= s_data)
m_wstrb  out  DATA_WIDTH/8  write strobe (= s_strb)
m_wvalid  out  1  write beat valid
m_wlast  out  1  last beat of current burst
m_wready  in  1  write channel ready
bready  out  1  response ready, constant 1 outside reset
bresp  in  1  one-cycle pulse per completed burst
idle  out  1  no job active
done  out  1  job complete, level

Behaviour:
Reset values:
- `wr_req`=0, `wr_address`=0, `wr_len`=0, `s_ready`=0, `m_wvalid`=0, `m_wlast`=0, `bready`=0, `idle`=1, `done`=0.
- All counters and the burst-length FIFO are cleared.
- Reset mid-job aborts immediately with no further requests or beats.

Job setup:
- `total_beats` = ceil(len/64), computed with 33-bit arithmetic.
- `start` is accepted only when `idle`=1 and is ignored otherwise.
- On accept: `idle`←0, `done`←0, latch `des_addr`.

Request FSM:
- IDLE -start-> CALC.
- CALC (1 cycle):
  - `burst` = min(remaining_beats, MAX_BURST, 64 − addr[11:6]). Bursts never cross a 4 KB boundary.
  - If remaining_beats=0, go to DRAIN.
  - Else if outstanding < MAX_OUTSTANDING, go to REQ.
  - Else stay in CALC.
- REQ:
  - `wr_req`=1 with `wr_address`/`wr_len`=burst−1 held stable until `wr_req_ack`.
  - On ack: addr += burst·64, remaining −= burst, granted += burst, outstanding += 1, push burst into length FIFO; go to CALC.
  - `wr_req` deasserts the cycle after ack.
- DRAIN:
  - Wait for sent_beats = total_beats and outstanding = 0.
  - Then go to DONE: `done`=1, `idle`=1, back to IDLE.
  - `done` holds until the next accepted `start`.

Data path:
- Combinational: `m_wvalid` = `s_valid` & (granted > sent); `s_ready` = `m_wready` & (granted > sent).
- `m_wlast` = `m_wvalid` & (beat_in_burst = FIFO head − 1).
- Each handshake: sent += 1, beat_in_burst += 1.
- On a last-beat handshake: pop FIFO, beat_in_burst←0.
- An ack in the same cycle the FIFO is empty makes data eligible from the following cycle (granted is registered).

Outstanding counter:
- +1 on ack, −1 on `bresp`; unchanged when both occur in the same cycle.
- A `bresp` with outstanding=0 is ignored.
- The FIFO never overflows because outstanding ≤ MAX_OUTSTANDING gates requests.

Zero-length job:
- CALC → DRAIN → DONE with no `wr_req`.
- `done` is high 3 cycles after `start`.

Test Plan:
- len=4096, addr=0x1000, always-ready sink → one request addr 0x1000 `wr_len`=63; 64 beats with `m_wlast` on beat 64; one `bresp` → `done`=1.
- len=200, addr=0x0FC0 → bursts (0x0FC0, len 0) then (0x1000, len 2); total 4 beats; `wlast` on beats 1 and 4.
- MAX_OUTSTANDING=2, len=64·64·4 (4 bursts), `bresp` withheld → exactly 2 acks then `wr_req` stays low; releasing one `bresp` allows the 3rd request.
- Upstream `s_valid` high before any ack → `m_wvalid`=0, `s_ready`=0 until the cycle after the first ack.
- Same-cycle ack and `bresp` with outstanding=1 → outstanding remains 1; `done` only after the final `bresp`.
- len=0 → no `wr_req`, `done`=1 at start+3. Assert `rst` mid-burst → all outputs return to reset values asynchronously; `start` while busy is ignored.
